// File: rtl/cond_logic.sv
// Condition-check unit: evaluates the instruction condition field against the
// registered NZCV flags and gates the flag, register, memory and branch writes.
module cond_logic #(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       BranchX,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       BranchXTaken,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic       n_flag;
   logic       z_flag;
   logic       c_flag;
   logic       v_flag;
   logic       cond_ex;

   assign n_flag = flags_q[3];
   assign z_flag = flags_q[2];
   assign c_flag = flags_q[1];
   assign v_flag = flags_q[0];

   // Evaluated only from the registered flags, so a write this cycle cannot affect it.
   always_comb begin
      cond_ex = 1'b0;
      unique case (Cond)
         4'b0000: cond_ex = z_flag;
         4'b0001: cond_ex = ~z_flag;
         4'b0010: cond_ex = c_flag;
         4'b0011: cond_ex = ~c_flag;
         4'b0100: cond_ex = n_flag;
         4'b0101: cond_ex = ~n_flag;
         4'b0110: cond_ex = v_flag;
         4'b0111: cond_ex = ~v_flag;
         4'b1000: cond_ex = c_flag & ~z_flag;
         4'b1001: cond_ex = ~c_flag | z_flag;
         4'b1010: cond_ex = (n_flag == v_flag);
         4'b1011: cond_ex = (n_flag != v_flag);
         4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
         4'b1101: cond_ex = z_flag | (n_flag != v_flag);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // N/Z and C/V are written as independent halves.
   always_comb begin
      flags_d = flags_q;
      if (FlagW[1] && cond_ex) begin
         flags_d[3:2] = ALUFlags[3:2];
      end
      if (FlagW[0] && cond_ex) begin
         flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= FLAG_RESET;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign CondEx       = cond_ex;
   assign PCSrc        = PCS & cond_ex;
   assign RegWrite     = RegW & cond_ex & ~NoWrite;
   assign MemWrite     = MemW & cond_ex;
   assign BranchXTaken = BranchX & cond_ex;
   assign Flags        = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, a full condition
// sweep and randomized traffic against a behavioural model.
module tb_cond_logic;

   localparam logic [3:0] FR = 4'b0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic [1:0] flag_w;
   logic       pcs, reg_w, mem_w, branch_x, no_write;
   logic       pc_src, reg_write, mem_write, bx_taken, cond_ex;
   logic [3:0] flags;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] model_flags;

   always #5 clk = ~clk;

   cond_logic #(.FLAG_RESET(FR)) dut (
      .clk(clk), .rst_n(rst_n), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
      .PCS(pcs), .RegW(reg_w), .MemW(mem_w), .BranchX(branch_x), .NoWrite(no_write),
      .PCSrc(pc_src), .RegWrite(reg_write), .MemWrite(mem_write),
      .BranchXTaken(bx_taken), .CondEx(cond_ex), .Flags(flags)
   );

   // Reference: base predicate per condition pair, odd codes invert it; 1111 never runs.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
   endfunction

   task automatic apply(input logic r, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic p, input logic rw,
                        input logic mw, input logic bx, input logic nw);
      @(negedge clk);
      rst_n = r; cond = c; alu_flags = af; flag_w = fw;
      pcs = p; reg_w = rw; mem_w = mw; branch_x = bx; no_write = nw;
      #1;
   endtask

   // Advance one edge and update the model's notion of the flag register.
   task automatic step();
      logic [3:0] nxt;
      logic ok;
      ok  = cond_ok(cond, model_flags);
      nxt = model_flags;
      if (!rst_n) nxt = FR;
      else begin
         if (flag_w[1] && ok) nxt[3:2] = alu_flags[3:2];
         if (flag_w[0] && ok) nxt[1:0] = alu_flags[1:0];
      end
      @(posedge clk);
      #1;
      model_flags = nxt;
   endtask

   task automatic test_reset();
      model_flags = 4'hx;
      apply(0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
      step();
      n_cmp++;
      if (flags !== FR) begin
         n_err++; $display("FAIL reset_flags: got %b want %b", flags, FR);
      end
      apply(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      n_cmp++;
      if (cond_ex !== 1'b0) begin
         n_err++; $display("FAIL reset_eq: got %b want 0", cond_ex);
      end
      apply(0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      n_cmp++;
      if (cond_ex !== 1'b1) begin
         n_err++; $display("FAIL reset_ne: got %b want 1", cond_ex);
      end
      step();
      $display("test_reset done: flags=%b", flags);
   endtask

   task automatic test_scenarios();
      // Scenario 1
      apply(1, 4'hE, 4'h0, 2'b00, 0, 1, 1, 0, 0);
      n_cmp++;
      if ({reg_write, mem_write, flags} !== {2'b11, 4'b0000}) begin
         n_err++; $display("FAIL scen1: got rw=%b mw=%b fl=%b want 1 1 0000", reg_write, mem_write, flags);
      end
      // Scenario 2: CMP equal
      apply(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 0, 1);
      n_cmp++;
      if (reg_write !== 1'b0) begin
         n_err++; $display("FAIL scen2_nowrite: got %b want 0", reg_write);
      end
      step();
      n_cmp++;
      if (flags !== 4'b0100) begin
         n_err++; $display("FAIL scen2_flags: got %b want 0100", flags);
      end
      apply(1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0);
      n_cmp++;
      if (pc_src !== 1'b1) begin
         n_err++; $display("FAIL scen2_beq: got %b want 1", pc_src);
      end
      apply(1, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 0);
      n_cmp++;
      if (pc_src !== 1'b0) begin
         n_err++; $display("FAIL scen2_bne: got %b want 0", pc_src);
      end
      // Scenario 3: failing condition blocks everything
      apply(1, 4'h1, 4'b1010, 2'b11, 1, 1, 1, 1, 0);
      n_cmp++;
      if ({cond_ex, pc_src, reg_write, mem_write, bx_taken} !== 5'b0) begin
         n_err++; $display("FAIL scen3_block: got %b want 00000",
                           {cond_ex, pc_src, reg_write, mem_write, bx_taken});
      end
      step();
      n_cmp++;
      if (flags !== 4'b0100) begin
         n_err++; $display("FAIL scen3_hold: got %b want 0100", flags);
      end
      // Scenario 4: N/Z-only write
      apply(1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
      step();
      apply(1, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0, 0);
      step();
      n_cmp++;
      if (flags !== 4'b0011) begin
         n_err++; $display("FAIL scen4_half: got %b want 0011", flags);
      end
      // Scenario 6: reset overrides write; BX taken under AL
      apply(0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 1, 0);
      n_cmp++;
      if (bx_taken !== 1'b1) begin
         n_err++; $display("FAIL scen6_bx: got %b want 1", bx_taken);
      end
      step();
      n_cmp++;
      if (flags !== FR) begin
         n_err++; $display("FAIL scen6_rst: got %b want %b", flags, FR);
      end
      $display("test_scenarios done: flags=%b", flags);
   endtask

   task automatic test_sweep();
      logic [3:0] fv, cv;
      logic exp;
      for (int f = 0; f < 16; f++) begin
         fv = 4'(f);
         apply(1, 4'hE, fv, 2'b11, 0, 0, 0, 0, 0);
         step();
         n_cmp++;
         if (flags !== fv) begin
            n_err++; $display("FAIL sweep_load: got %b want %b", flags, fv);
         end
         for (int c = 0; c < 16; c++) begin
            cv = 4'(c);
            apply(1, cv, 4'h0, 2'b00, 0, 0, 0, 0, 0);
            exp = cond_ok(cv, fv);
            n_cmp++;
            if (cond_ex !== exp) begin
               n_err++; $display("FAIL sweep_condex: cond=%b flags=%b got %b want %b", cv, fv, cond_ex, exp);
            end
         end
         $display("test_sweep flags=%b: 16 conds checked", fv);
      end
   endtask

   task automatic test_back_to_back();
      model_flags = flags;
      apply(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
      step();
      // EQ now true from the new Z; clearing Z must not affect this cycle
      apply(1, 4'h0, 4'b0000, 2'b11, 0, 1, 0, 0, 0);
      n_cmp++;
      if ({cond_ex, reg_write} !== 2'b11) begin
         n_err++; $display("FAIL b2b_first: got %b want 11", {cond_ex, reg_write});
      end
      step();
      apply(1, 4'h0, 4'b0100, 2'b11, 0, 1, 0, 0, 0);
      n_cmp++;
      if ({cond_ex, reg_write} !== 2'b00) begin
         n_err++; $display("FAIL b2b_second: got %b want 00", {cond_ex, reg_write});
      end
      step();
      n_cmp++;
      if (flags !== 4'b0000) begin
         n_err++; $display("FAIL b2b_hold: got %b want 0000", flags);
      end
      $display("test_back_to_back done: flags=%b", flags);
   endtask

   task automatic test_random();
      logic ok;
      model_flags = flags;
      for (int i = 0; i < 300; i++) begin
         apply(($urandom_range(0, 19) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         ok = cond_ok(cond, model_flags);
         n_cmp++;
         if ({cond_ex, pc_src, reg_write, mem_write, bx_taken} !==
             {ok, pcs & ok, reg_w & ok & !no_write, mem_w & ok, branch_x & ok}) begin
            n_err++;
            $display("FAIL rand_outs #%0d: got %b want %b", i,
                     {cond_ex, pc_src, reg_write, mem_write, bx_taken},
                     {ok, pcs & ok, reg_w & ok & !no_write, mem_w & ok, branch_x & ok});
         end
         step();
         n_cmp++;
         if (flags !== model_flags) begin
            n_err++; $display("FAIL rand_flags #%0d: got %b want %b", i, flags, model_flags);
         end
         $display("rand #%0d cond=%b fw=%b alu=%b rst_n=%b flags=%b", i, cond, flag_w, alu_flags, rst_n, flags);
      end
   endtask

   initial begin
      rst_n = 0; cond = 4'hE; alu_flags = 0; flag_w = 0;
      pcs = 0; reg_w = 0; mem_w = 0; branch_x = 0; no_write = 0;
      test_reset();
      test_scenarios();
      test_sweep();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
